// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: data word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-RAM arbiter for the dcache and icache ports: dcache priority, unbroken
// two-word dcache bursts, and an icache starvation counter that forces icache in.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  // dcache port
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  word_t             dstore,
  output logic              dwait,
  output word_t             dload,
  // icache port
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output word_t             iload,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output word_t             ramstore,
  input  word_t             ramload,
  input  ramstate_t         ramstate,
  output logic              merr
);

  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state_q, state_d;
  logic             beat_q, beat_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             merr_q, merr_d;

  logic             d_req;
  logic             ram_ack;
  logic             starve_full;
  logic [CNT_W-1:0] starve_inc;

  assign d_req       = dREN | dWEN;
  assign ram_ack     = (ramstate == ACCESS);
  assign starve_full = (starve_q >= CNT_MAX);
  // Saturating increment so the counter can never pass STARVE_MAX.
  assign starve_inc  = starve_full ? CNT_MAX : CNT_W'(starve_q + CNT_W'(1));

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      beat_q   <= 1'b0;
      starve_q <= '0;
      merr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
      merr_q   <= merr_d;
    end
  end

  // Next-state logic for grant, burst beat, starvation counter and error flag
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    starve_d = starve_q;
    merr_d   = merr_q | ((state_q != IDLE) && (ramstate == ERROR));

    unique case (state_q)
      IDLE: begin
        beat_d = 1'b0;
        if (!iREN) begin
          starve_d = '0;
        end
        if (d_req && !(iREN && starve_full)) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end

      DGRANT: begin
        if (!d_req) begin
          state_d = IDLE;
          beat_d  = 1'b0;
        end else if (ram_ack) begin
          beat_d = ~beat_q;
          // Burst boundary: only here may a waiting icache be forced in.
          if (beat_q && iREN) begin
            starve_d = starve_inc;
            if (starve_inc == CNT_MAX) begin
              state_d = IGRANT;
            end
          end
        end
      end

      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_ack) begin
          starve_d = '0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        beat_d  = 1'b0;
      end
    endcase
  end

  // Output decode: RAM steering and per-port wait/load
  always_comb begin
    dwait    = 1'b1;
    iwait    = 1'b1;
    dload    = '0;
    iload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    unique case (state_q)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (d_req && ram_ack) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end

      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (iREN && ram_ack) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end

      default: ;
    endcase
  end

  assign merr = merr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the RAM by driving ramstate/ramload.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              dREN, dWEN, iREN;
  logic [ADDR_W-1:0] daddr, iaddr;
  word_t             dstore, ramload;
  ramstate_t         ramstate;
  logic              dwait, iwait, ramREN, ramWEN, merr;
  word_t             dload, iload, ramstore;
  logic [ADDR_W-1:0] ramaddr;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0; dREN = 0; dWEN = 0; iREN = 0;
    daddr = '0; iaddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #12;
    checks++;
    if ({ramREN, ramWEN, dwait, iwait, merr} !== 5'b00110) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected %b", {ramREN, ramWEN, dwait, iwait, merr}, 5'b00110);
    end
    checks++;
    if ({ramaddr, ramstore, dload, iload} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {ramaddr, ramstore, dload, iload});
    end
    cyc(); nRST = 1'b1;
  endtask

  task automatic test_read();
    cyc(); dREN = 1; daddr = 32'h40; ramstate = FREE; #1;
    checks++;
    if (ramREN !== 1'b0) begin errors++; $display("FAIL rd_c1_ramREN: got %b expected 0", ramREN); end
    for (int i = 0; i < 2; i++) begin
      cyc(); ramstate = BUSY; #1;
      checks++;
      if ({ramREN, dwait, ramaddr} !== {1'b1, 1'b1, 32'h40}) begin
        errors++;
        $display("FAIL rd_busy%0d: got %b/%b/%h expected 1/1/00000040", i, ramREN, dwait, ramaddr);
      end
    end
    cyc(); ramstate = ACCESS; ramload = 32'hDEAD_BEEF; #1;
    checks++;
    if ({dwait, iwait, dload} !== {1'b0, 1'b1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL rd_access: got dwait=%b iwait=%b dload=%h expected 0/1/deadbeef", dwait, iwait, dload);
    end
    cyc(); dREN = 0; ramstate = FREE; #1;
    checks++;
    if ({dwait, ramREN, dload} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rd_after: got dwait=%b ramREN=%b dload=%h expected 1/0/0", dwait, ramREN, dload);
    end
    cyc(); #1;
    checks++;
    if ({ramREN, ramaddr} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL rd_idle: got %b/%h expected 0/0", ramREN, ramaddr);
    end
  endtask

  task automatic test_burst_priority();
    cyc(); iREN = 1; iaddr = 32'h200; dWEN = 1; daddr = 32'h80; dstore = 32'h11; ramstate = FREE; #1;
    checks++;
    if (ramWEN !== 1'b0) begin errors++; $display("FAIL bw_idle_ramWEN: got %b expected 0", ramWEN); end
    cyc(); ramstate = ACCESS; #1;
    checks++;
    if ({ramWEN, ramREN, ramaddr, ramstore, dwait} !== {1'b1, 1'b0, 32'h80, 32'h11, 1'b0}) begin
      errors++;
      $display("FAIL bw_word0: got %b%b %h %h %b expected 10 00000080 00000011 0", ramWEN, ramREN, ramaddr, ramstore, dwait);
    end
    cyc(); daddr = 32'h84; dstore = 32'h22; #1;
    checks++;
    if ({ramWEN, ramaddr, ramstore, dwait, iwait} !== {1'b1, 32'h84, 32'h22, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bw_word1: got %b %h %h %b %b expected 1 00000084 00000022 0 1", ramWEN, ramaddr, ramstore, dwait, iwait);
    end
    cyc(); dWEN = 0; ramstate = FREE; #1;
    checks++;
    if ({ramWEN, ramREN, iwait} !== 3'b001 || ramaddr === iaddr) begin
      errors++; $display("FAIL bw_drop: got %b%b%b addr=%h expected 001 addr!=iaddr", ramWEN, ramREN, iwait, ramaddr);
    end
    cyc(); #1;
    checks++;
    if ({ramREN, iwait} !== 2'b01) begin errors++; $display("FAIL bw_idle2: got %b expected 01", {ramREN, iwait}); end
    cyc(); ramstate = ACCESS; ramload = 32'hCAFE_F00D; #1;
    checks++;
    if ({ramREN, ramaddr, iwait, iload, dwait} !== {1'b1, 32'h200, 1'b0, 32'hCAFE_F00D, 1'b1}) begin
      errors++;
      $display("FAIL bw_iserve: got %b %h %b %h %b expected 1 00000200 0 cafef00d 1", ramREN, ramaddr, iwait, iload, dwait);
    end
    cyc(); iREN = 0; ramstate = FREE; #1;
    checks++;
    if (iwait !== 1'b1) begin errors++; $display("FAIL bw_iwait_after: got %b expected 1", iwait); end
  endtask

  task automatic test_rw_both();
    cyc(); dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'h77; #1;
    cyc(); #1;
    checks++;
    if ({ramWEN, ramREN, ramaddr} !== {1'b1, 1'b0, 32'h100}) begin
      errors++; $display("FAIL both_rw: got %b%b %h expected 10 00000100", ramWEN, ramREN, ramaddr);
    end
    cyc(); dREN = 0; dWEN = 0; #1;
    cyc(); #1;
  endtask

  task automatic test_starvation();
    cyc(); dREN = 1; daddr = 32'h400; iREN = 1; iaddr = 32'h300; ramstate = FREE; #1;
    for (int b = 0; b < STARVE_MAX; b++) begin
      for (int w = 0; w < 2; w++) begin
        cyc(); ramstate = ACCESS; ramload = 32'(b * 2 + w); #1;
        checks++;
        if ({dwait, iwait, ramaddr, dload} !== {1'b0, 1'b1, 32'h400, 32'(b * 2 + w)}) begin
          errors++;
          $display("FAIL st_burst%0d_w%0d: got %b %b %h %h expected 0 1 00000400 %h", b, w, dwait, iwait, ramaddr, dload, 32'(b * 2 + w));
        end
      end
    end
    cyc(); ramstate = BUSY; #1;
    checks++;
    if ({ramREN, ramaddr, dwait, iwait} !== {1'b1, 32'h300, 1'b1, 1'b1}) begin
      errors++; $display("FAIL st_forced_igrant: got %b %h %b %b expected 1 00000300 1 1", ramREN, ramaddr, dwait, iwait);
    end
    cyc(); ramstate = ACCESS; ramload = 32'h1234_5678; #1;
    checks++;
    if ({iwait, iload, dwait} !== {1'b0, 32'h1234_5678, 1'b1}) begin
      errors++; $display("FAIL st_iload: got %b %h %b expected 0 12345678 1", iwait, iload, dwait);
    end
    cyc(); ramstate = FREE; #1;
    checks++;
    if ({ramREN, iwait} !== 2'b01) begin errors++; $display("FAIL st_back_idle: got %b expected 01", {ramREN, iwait}); end
    // Counter back at zero: one more full burst must leave dcache granted.
    for (int w = 0; w < 2; w++) begin
      cyc(); ramstate = ACCESS; #1;
    end
    cyc(); ramstate = BUSY; #1;
    checks++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h400}) begin
      errors++; $display("FAIL st_cnt_cleared: got %b %h expected 1 00000400", ramREN, ramaddr);
    end
    cyc(); dREN = 0; iREN = 0; ramstate = FREE; #1;
    cyc(); #1;
  endtask

  task automatic test_idrop();
    cyc(); iREN = 1; iaddr = 32'h500; ramstate = FREE; #1;
    cyc(); ramstate = BUSY; #1;
    checks++;
    if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h500, 1'b1}) begin
      errors++; $display("FAIL idrop_busy: got %b %h %b expected 1 00000500 1", ramREN, ramaddr, iwait);
    end
    cyc(); iREN = 0; #1;
    checks++;
    if ({ramREN, iwait} !== 2'b01) begin errors++; $display("FAIL idrop_now: got %b expected 01", {ramREN, iwait}); end
    cyc(); #1;
    checks++;
    if ({ramREN, ramaddr, iwait} !== {1'b0, 32'h0, 1'b1}) begin
      errors++; $display("FAIL idrop_idle: got %b %h %b expected 0 00000000 1", ramREN, ramaddr, iwait);
    end
    // dcache drop coinciding with ACCESS is not acknowledged
    cyc(); ramstate = FREE; dREN = 1; daddr = 32'h700; #1;
    cyc(); dREN = 0; ramstate = ACCESS; ramload = 32'h55; #1;
    checks++;
    if ({dwait, dload, ramREN} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL ddrop_access: got %b %h %b expected 1 00000000 0", dwait, dload, ramREN);
    end
    cyc(); ramstate = FREE; #1;
    checks++;
    if ({ramREN, ramaddr} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL ddrop_idle: got %b %h expected 0 0", ramREN, ramaddr);
    end
  endtask

  task automatic test_error_reset();
    cyc(); dREN = 1; daddr = 32'h600; dstore = 32'hABCD; ramstate = FREE; #1;
    cyc(); ramstate = ERROR; #1;
    checks++;
    if (dwait !== 1'b1) begin errors++; $display("FAIL err_dwait: got %b expected 1", dwait); end
    cyc(); ramstate = FREE; #1;
    checks++;
    if ({merr, dwait} !== 2'b11) begin errors++; $display("FAIL err_set: got %b expected 11", {merr, dwait}); end
    cyc(); ramstate = BUSY; #1;
    checks++;
    if ({merr, ramREN} !== 2'b11) begin errors++; $display("FAIL err_held: got %b expected 11", {merr, ramREN}); end
    nRST = 1'b0; #1;
    checks++;
    if ({ramREN, ramWEN, dwait, iwait, merr} !== 5'b00110 || {ramaddr, ramstore, dload, iload} !== 128'h0) begin
      errors++;
      $display("FAIL async_reset: got ctl=%b addr=%h store=%h expected 00110 0 0", {ramREN, ramWEN, dwait, iwait, merr}, ramaddr, ramstore);
    end
    cyc(); nRST = 1'b1; dREN = 0; ramstate = FREE; #1;
    checks++;
    if ({merr, ramREN} !== 2'b00) begin errors++; $display("FAIL post_reset: got %b expected 00", {merr, ramREN}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read();
    test_burst_priority();
    test_rw_both();
    test_starvation();
    test_idrop();
    test_error_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
